// File: rtl/div_result_buf.sv
// div_result_buf: result FIFO and issue-credit tracker for the pipelined
// restoring divider. Each rdy strobe from the divider is captured into a
// DEPTH-entry FIFO presented on a valid/ready port. Because the divider cannot
// stall, can_issue is only high while every in-flight op has a guaranteed slot.
module div_result_buf #(
    parameter int N     = 5,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic          res_rdy,
    input  logic [N-1:0]  res_merchant,
    input  logic [N-1:0]  res_remainder,
    output logic          can_issue,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_merchant,
    output logic [N-1:0]  out_remainder,
    output logic [CW-1:0] fifo_cnt,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [2*N-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  in_flight;
    logic           push;
    logic           pop;
    logic           full;
    logic [CW:0]    credit_sum;

    // Handshake decode; a full FIFO still accepts a push when the head leaves
    // on the same edge, since the popped slot is reused.
    always_comb begin
        full       = (fifo_cnt == CW'(DEPTH));
        pop        = out_valid && out_ready;
        push       = res_rdy && (!full || pop);
        credit_sum = {1'b0, in_flight} + {1'b0, fifo_cnt};
    end

    assign out_valid = (fifo_cnt != '0);
    // Credits come from registered state only, so upstream sees a stable value.
    assign can_issue = (credit_sum < (CW+1)'(DEPTH));
    assign {out_merchant, out_remainder} = mem[rd_ptr];

    // One register bank per entry; only the slot under wr_ptr loads on push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry storage, cleared on reset so the data outputs start at 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem[gi] <= '0;
                end else if (push && (wr_ptr == AW'(gi))) begin
                    mem[gi] <= {res_merchant, res_remainder};
                end
            end
        end
    endgenerate

    // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Sticky drop flag: a result arrived with no room and no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (res_rdy && !push) begin
            overflow <= 1'b1;
        end
    end

    // Ops launched but not yet returned, saturating at both 0 and DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({issue, res_rdy})
                2'b10: if (in_flight != CW'(DEPTH)) in_flight <= in_flight + 1'b1;
                2'b01: if (in_flight != '0)         in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_buf.sv
// Directed bench for div_result_buf: a per-cycle vector table covering single
// op, credit limit, full with simultaneous push/pop and forced overflow, then
// hand-written async reset and a wrap-around stream with random out_ready.
module tb_div_result_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue = 1'b0;
    logic       res_rdy = 1'b0;
    logic [4:0] res_merchant = '0;
    logic [4:0] res_remainder = '0;
    logic       can_issue;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_merchant;
    logic [4:0] out_remainder;
    logic [2:0] fifo_cnt;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_result_buf #(.N(5), .DEPTH(4), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .res_rdy(res_rdy),
        .res_merchant(res_merchant), .res_remainder(res_remainder),
        .can_issue(can_issue), .out_valid(out_valid), .out_ready(out_ready),
        .out_merchant(out_merchant), .out_remainder(out_remainder),
        .fifo_cnt(fifo_cnt), .overflow(overflow)
    );

    typedef struct {
        logic       iss;
        logic       rr;
        logic [4:0] m;
        logic [4:0] r;
        logic       ordy;
        logic       ci;
        logic       ov;
        logic [4:0] em;
        logic [4:0] er;
        logic [2:0] cnt;
        logic       of;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iss, logic rr, logic [4:0] m, logic [4:0] r,
                                logic ordy, logic ci, logic ov, logic [4:0] em,
                                logic [4:0] er, logic [2:0] cnt, logic of);
        vec_t v;
        v.iss = iss; v.rr = rr; v.m = m; v.r = r; v.ordy = ordy;
        v.ci = ci; v.ov = ov; v.em = em; v.er = er; v.cnt = cnt; v.of = of;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_can_issue"}, int'(can_issue), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_fifo_cnt"}, int'(fifo_cnt), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_merchant"}, int'(out_merchant), 0);
        chk({tag, "_remainder"}, int'(out_remainder), 0);
    endtask

    initial begin
        int q_m[$];
        int q_r[$];
        int exp_cnt;
        int sent;
        int got;
        int cyc;
        logic do_rr;
        logic do_pop;

        // ---------- reset ----------
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---------- vector table: state expected after each edge ----------
        //                iss rr  m   r  rdy  ci ov  em  er cnt of
        // single op 13/3 -> 4 r 1
        tbl.push_back(mk(1, 0, 0,  0,  0,  1, 0,  0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 4,  1,  0,  1, 1,  4,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 0,  0,  0, 0, 0));
        // credit limit: four issues, results 15r1 6r2 1r0 2r1
        tbl.push_back(mk(1, 0, 0,  0,  0,  1, 0,  0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0,  0,  1, 0,  0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0,  0,  1, 0,  0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0,  0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 15, 1,  0,  0, 1, 15,  1, 1, 0));
        tbl.push_back(mk(0, 1, 6,  2,  0,  0, 1, 15,  1, 2, 0));
        tbl.push_back(mk(0, 1, 1,  0,  0,  0, 1, 15,  1, 3, 0));
        tbl.push_back(mk(0, 1, 2,  1,  0,  0, 1, 15,  1, 4, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 1,  6,  2, 3, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 1,  1,  0, 2, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 1,  2,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 0,  0,  0, 0, 0));
        // full + simultaneous push/pop (in_flight stays saturated at 0)
        tbl.push_back(mk(0, 1, 1,  1,  0,  1, 1,  1,  1, 1, 0));
        tbl.push_back(mk(0, 1, 2,  2,  0,  1, 1,  1,  1, 2, 0));
        tbl.push_back(mk(0, 1, 3,  3,  0,  1, 1,  1,  1, 3, 0));
        tbl.push_back(mk(0, 1, 4,  4,  0,  0, 1,  1,  1, 4, 0));
        tbl.push_back(mk(0, 1, 5,  5,  1,  0, 1,  2,  2, 4, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 1,  3,  3, 3, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 1,  4,  4, 2, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 1,  5,  5, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 0,  0,  0, 0, 0));
        // forced overflow
        tbl.push_back(mk(0, 1, 6,  0,  0,  1, 1,  6,  0, 1, 0));
        tbl.push_back(mk(0, 1, 7,  1,  0,  1, 1,  6,  0, 2, 0));
        tbl.push_back(mk(0, 1, 8,  2,  0,  1, 1,  6,  0, 3, 0));
        tbl.push_back(mk(0, 1, 9,  3,  0,  0, 1,  6,  0, 4, 0));
        tbl.push_back(mk(0, 1, 10, 10, 0,  0, 1,  6,  0, 4, 1));
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 1,  6,  0, 4, 1));
        tbl.push_back(mk(0, 0, 0,  0,  1,  1, 1,  7,  1, 3, 1));
        // 3 entries stored, two more in flight (second one over-issued)
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 1,  7,  1, 3, 1));
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 1,  7,  1, 3, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            issue = tbl[i].iss; res_rdy = tbl[i].rr;
            res_merchant = tbl[i].m; res_remainder = tbl[i].r;
            out_ready = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_can_issue", i), int'(can_issue), int'(tbl[i].ci));
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
            chk($sformatf("v%0d_fifo_cnt", i), int'(fifo_cnt), int'(tbl[i].cnt));
            chk($sformatf("v%0d_overflow", i), int'(overflow), int'(tbl[i].of));
            if (tbl[i].ov) begin
                chk($sformatf("v%0d_merchant", i), int'(out_merchant), int'(tbl[i].em));
                chk($sformatf("v%0d_remainder", i), int'(out_remainder), int'(tbl[i].er));
            end
            $display("vec %0d: ci=%0d valid=%0d cnt=%0d ovf=%0d head=%0d/%0d",
                     i, can_issue, out_valid, fifo_cnt, overflow, out_merchant, out_remainder);
        end

        // ---------- async reset mid-cycle ----------
        @(negedge clk);
        issue = 1'b0; res_rdy = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("post_rst");
        $display("async reset: ci=%0d valid=%0d cnt=%0d ovf=%0d", can_issue, out_valid, fifo_cnt, overflow);

        // ---------- pointer wrap: 10 results, random out_ready ----------
        exp_cnt = 0; sent = 0; got = 0; cyc = 0;
        while ((got < 10) && (cyc < 300)) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            do_rr = (sent < 10) && (exp_cnt < 4);
            do_pop = (exp_cnt > 0) && out_ready;
            res_rdy = do_rr;
            res_merchant = 5'(sent + 1);
            res_remainder = 5'(31 - sent);
            if (do_pop) begin
                chk($sformatf("wrap%0d_merchant", got), int'(out_merchant), q_m[0]);
                chk($sformatf("wrap%0d_remainder", got), int'(out_remainder), q_r[0]);
                $display("wrap pop %0d: %0d/%0d", got, out_merchant, out_remainder);
                void'(q_m.pop_front());
                void'(q_r.pop_front());
                got++;
            end
            if (do_rr) begin
                q_m.push_back(sent + 1);
                q_r.push_back(31 - sent);
                sent++;
            end
            exp_cnt = exp_cnt + (do_rr ? 1 : 0) - (do_pop ? 1 : 0);
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        res_rdy = 1'b0; out_ready = 1'b0;
        chk("wrap_received", got, 10);
        chk("wrap_fifo_cnt", int'(fifo_cnt), 0);
        chk("wrap_overflow", int'(overflow), 0);
        chk("wrap_can_issue", int'(can_issue), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_result_buf.md
# div_result_buf

Result buffer and issue-credit controller that sits directly downstream of the pipelined restoring divider. Captures each quotient/remainder pair on the divider's one-cycle `rdy` strobe into a small FIFO and presents it on a valid/ready output port. The divider pipeline cannot stall, so the block also counts in-flight operations and raises `can_issue` only when a result slot is guaranteed. Upstream logic must gate its `data_rdy` pulses into the divider with `can_issue`.

## Interface
- `N`, 5, dividend width; also the width of quotient (`merchant`) and remainder as produced by the divider.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CW`, 3, counter width; must hold 0..DEPTH inclusive (≥ log2(DEPTH)+1).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue`  in  1  copy of the `data_rdy` pulse sent into the divider; one operation launched per high cycle.
- `res_rdy`  in  1  divider `rdy` output; one result valid per high cycle.
- `res_merchant`  in  N  divider quotient, sampled when `res_rdy`=1.
- `res_remainder`  in  N  divider remainder, sampled when `res_rdy`=1.
- `can_issue`  out  1  high when `in_flight + fifo_cnt < DEPTH`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head entry when `out_valid`=1.
- `out_merchant`  out  N  head-entry quotient.
- `out_remainder`  out  N  head-entry remainder.
- `fifo_cnt`  out  CW  stored entries, 0..DEPTH.
- `overflow`  out  1  sticky; a result was dropped because the FIFO was full.

## Operation
- Storage: DEPTH × 2N-bit memory, `wr_ptr`/`rd_ptr` of log2(DEPTH) bits wrapping modulo DEPTH, `fifo_cnt` register.
- Push = `res_rdy` and (`fifo_cnt` < DEPTH or pop). Pop = `out_valid` and `out_ready`.
- Simultaneous push and pop: both happen, `fifo_cnt` unchanged; legal even when full (the popped slot is reused in the same edge).
- `res_rdy` while full with no pop: entry dropped, pointers/count unchanged, `overflow` set; cleared only by reset.
- `in_flight` counter (CW bits): +1 on `issue`, −1 on `res_rdy`, unchanged when both. Saturates at 0 (a `res_rdy` with `in_flight`=0 does not underflow; the result is still pushed) and at DEPTH.
- `can_issue` is combinational from registered `in_flight` and `fifo_cnt` only; it does not look at the current cycle's `issue`, `res_rdy` or pop. Upstream issues at most once per cycle.
- `issue` while `can_issue`=0 is counted anyway (no protection); the resulting overflow is reported via `overflow`.
- `out_merchant`/`out_remainder` = memory[`rd_ptr`]; hold value while `out_valid`=1 and `out_ready`=0. Content is don't-care when `out_valid`=0.
- `out_valid` = (`fifo_cnt` != 0).
- Operand semantics are unchanged: the block does not inspect values; divide-by-zero results pass through as produced.

## Timing
- Reset (async assert, sync-safe deassert by system): `fifo_cnt`=0, `in_flight`=0, pointers 0, `overflow`=0, `out_valid`=0, `can_issue`=1, data outputs 0 (memory reset to 0).
- Push latency: `res_rdy` high in cycle t → `out_valid`=1 and data visible from cycle t+1. No same-cycle bypass.
- Pop: entry removed at edge where `out_valid`&`out_ready`; next head visible the following cycle.
- `can_issue` reflects state after the edge: an `issue` at t lowers it at t+1 if the sum reaches DEPTH; a pop at t raises it at t+1.
- Full throughput: one push and one pop per cycle sustained indefinitely.
- Reset mid-operation discards all stored and in-flight accounting; the divider is reset by the same `rst_n`, so no stale results return.

## Test plan
- Reset, then single op 13/3: pulse `issue`; divider returns `res_rdy` with merchant 4, remainder 1 → `out_valid` next cycle, `out_merchant`=4, `out_remainder`=1; pop with `out_ready`=1 → `fifo_cnt` 0, `can_issue` 1.
- Credit limit, DEPTH=4, `out_ready`=0: issue four ops (31/2, 20/3, 7/7, 9/4) back-to-back → `can_issue` 0 from cycle after fourth issue; results 15r1, 6r2, 1r0, 2r1 drained in that order; `can_issue` returns 1 one cycle after first pop.
- Full + simultaneous push/pop: fill to 4, hold `out_ready`=1 while a fifth `res_rdy` arrives → no overflow, `fifo_cnt` stays 4, order preserved.
- Forced overflow: full FIFO, `out_ready`=0, drive `res_rdy` → `overflow`=1, `fifo_cnt` 4, stored data unchanged; stays 1 until `rst_n` low.
- Pointer wrap: stream 10 results with random `out_ready` → all 10 emerged in order, no loss, `overflow`=0.
- Async reset with 3 entries and 2 in flight: drop `rst_n` mid-cycle → outputs at reset values immediately, `can_issue`=1.
